// File: rtl/mem_access_unit_pkg.sv
// Shared control-unit constants: funct3 size codes, state encodings
// and the request legality check used by the memory access unit.
package mem_access_unit_pkg;

  localparam logic [2:0] FUNC_B  = 3'b000;
  localparam logic [2:0] FUNC_H  = 3'b001;
  localparam logic [2:0] FUNC_W  = 3'b010;
  localparam logic [2:0] FUNC_BU = 3'b100;
  localparam logic [2:0] FUNC_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Exactly one of load/store, a size valid for that kind, natural alignment
  function automatic logic req_legal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f,
    input logic [1:0] off
  );
    logic ok;
    case (f)
      FUNC_B:  ok = ld ^ st;
      FUNC_H:  ok = (ld ^ st) && !off[0];
      FUNC_W:  ok = (ld ^ st) && (off == 2'b00);
      FUNC_BU: ok = ld && !st;
      FUNC_HU: ok = ld && !st && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte enables and replicated data,
// plus extraction and extension of the addressed load lane.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  func,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_val
);

  logic [31:0] lane;
  logic        sx;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0;
    load_val  = 32'h0;
    lane      = mem_rdata >> {off, 3'b000};
    sx        = ~func[2];
    case (func[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        load_val  = {{24{sx & lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        load_val  = {{16{sx & lane[15]}}, lane[15:0]};
      end
      2'b10: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_val  = lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-access load/store engine: IDLE -> ACCESS -> DONE with
// registered bus outputs, ack timeout and load-data extension.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [31:0] TMO = 32'(ACK_TIMEOUT);

  state_t      state;
  logic [31:0] cnt;
  logic        lat_load;
  logic [2:0]  lat_func;
  logic [1:0]  lat_off;

  logic [2:0]  al_func;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  // Live request fields steer the lanes at accept, latched ones afterwards
  assign al_func = (state == IDLE) ? func : lat_func;
  assign al_off  = (state == IDLE) ? addr[1:0] : lat_off;

  mem_lane_align u_align (
    .func      (al_func),
    .off       (al_off),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_val  (al_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 32'h0;
      lat_load  <= 1'b0;
      lat_func  <= 3'b000;
      lat_off   <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lat_load <= is_load;
            lat_func <= func;
            lat_off  <= addr[1:0];
            err      <= 1'b0;
            busy     <= 1'b1;
            mem_addr <= {addr[31:2], 2'b00};
            if (req_legal(is_load, is_store, func, addr[1:0])) begin
              state     <= ACCESS;
              cnt       <= 32'h0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            if (lat_load)
              rdata <= al_load;
          end else begin
            cnt <= cnt + 32'd1;
            if (cnt + 32'd1 == TMO) begin
              state   <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              rdata   <= 32'h0;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              mem_be  <= 4'b0000;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short ack timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  func;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_load   (is_load),
    .is_store  (is_store),
    .func      (func),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic ld, input logic st, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wd);
    is_load  = ld;
    is_store = st;
    func     = f;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    func = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    tick();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    tick();

    // LB at offset 3, ack in first ACCESS cycle
    req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_req", {31'h0, mem_req}, 32'h1);
    chk("lb_busy", {31'h0, busy}, 32'h1);
    chk("lb_we", {31'h0, mem_we}, 32'h0);
    chk("lb_be", {28'h0, mem_be}, 32'h8);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_done_early", {31'h0, done}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h80FFFFFF;
    tick();
    mem_ack = 1'b0;
    chk("lb_done", {31'h0, done}, 32'h1);
    chk("lb_err", {31'h0, err}, 32'h0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_req_drop", {31'h0, mem_req}, 32'h0);
    tick();
    chk("lb_idle_busy", {31'h0, busy}, 32'h0);
    chk("lb_idle_done", {31'h0, done}, 32'h0);

    // SH at offset 2, ack on third ACCESS cycle
    req(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", {31'h0, mem_req}, 32'h1);
      chk("sh_we", {31'h0, mem_we}, 32'h1);
      chk("sh_be", {28'h0, mem_be}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'hABCDABCD);
      chk("sh_addr", mem_addr, 32'h20);
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("sh_done", {31'h0, done}, 32'h1);
    chk("sh_err", {31'h0, err}, 32'h0);
    chk("sh_rdata_kept", rdata, 32'hFFFFFF80);
    tick();

    // Misaligned LW is rejected without a bus request
    req(1'b1, 1'b0, 3'b010, 32'h41, 32'h0);
    chk("lw_mis_req", {31'h0, mem_req}, 32'h0);
    chk("lw_mis_done", {31'h0, done}, 32'h1);
    chk("lw_mis_err", {31'h0, err}, 32'h1);
    tick();
    chk("lw_mis_idle", {31'h0, busy}, 32'h0);

    // LHU at offset 2
    req(1'b1, 1'b0, 3'b101, 32'h42, 32'h0);
    chk("lhu_be", {28'h0, mem_be}, 32'hC);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF0000;
    tick();
    mem_ack = 1'b0;
    chk("lhu_done", {31'h0, done}, 32'h1);
    chk("lhu_err", {31'h0, err}, 32'h0);
    chk("lhu_rdata", rdata, 32'h0000BEEF);
    tick();

    // Timeout: 4 ACCESS cycles with no ack
    req(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", {31'h0, mem_req}, 32'h1);
      chk("tmo_no_done", {31'h0, done}, 32'h0);
      tick();
    end
    chk("tmo_done", {31'h0, done}, 32'h1);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_rdata", rdata, 32'h0);
    chk("tmo_req_drop", {31'h0, mem_req}, 32'h0);
    tick();

    // Ack on the 4th cycle beats the timeout
    req(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_ack_req", {31'h0, mem_req}, 32'h1);
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'h11223344;
      end
      tick();
    end
    mem_ack = 1'b0;
    chk("tmo_ack_done", {31'h0, done}, 32'h1);
    chk("tmo_ack_err", {31'h0, err}, 32'h0);
    chk("tmo_ack_rdata", rdata, 32'h11223344);
    tick();

    // Asynchronous reset mid-ACCESS abandons the access
    req(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("rst_mid_req_pre", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    #1 reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    chk("rst_ack_done1", {31'h0, done}, 32'h0);
    tick();
    chk("rst_ack_done2", {31'h0, done}, 32'h0);
    chk("rst_ack_busy", {31'h0, busy}, 32'h0);
    mem_ack = 1'b0;

    // start held through ACCESS and DONE: one access only
    is_load = 1'b1; is_store = 1'b0; func = 3'b100; addr = 32'h1;
    mem_rdata = 32'h0000F000; mem_ack = 1'b1; start = 1'b1;
    tick();
    chk("hold_req", {31'h0, mem_req}, 32'h1);
    tick();
    chk("hold_done", {31'h0, done}, 32'h1);
    chk("hold_rdata", rdata, 32'h000000F0);
    tick();
    start = 1'b0; mem_ack = 1'b0;
    chk("hold_no_restart", {31'h0, busy}, 32'h0);
    chk("hold_done_clr", {31'h0, done}, 32'h0);
    tick();
    chk("hold_idle", {31'h0, busy}, 32'h0);

    // Load and store both asserted
    req(1'b1, 1'b1, 3'b000, 32'h10, 32'h0);
    chk("ldst_req", {31'h0, mem_req}, 32'h0);
    chk("ldst_done", {31'h0, done}, 32'h1);
    chk("ldst_err", {31'h0, err}, 32'h1);
    tick();

    // Store with load-only size code
    req(1'b0, 1'b1, 3'b100, 32'h10, 32'h0);
    chk("sbu_req", {31'h0, mem_req}, 32'h0);
    chk("sbu_err", {31'h0, err}, 32'h1);
    tick();

    // SB at offset 1 replicates the byte
    req(1'b0, 1'b1, 3'b000, 32'h205, 32'hCAFE005A);
    chk("sb_be", {28'h0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("sb_addr", mem_addr, 32'h204);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_err", {31'h0, err}, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, meaning the number of ACCESS cycles allowed without mem_ack before the access is aborted.
REQ-002 SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to perform one memory access; sampled only while busy=0.
REQ-006 is_load  input  1  access is a load (from control unit).
REQ-007 is_store  input  1  access is a store (from control unit).
REQ-008 func  input  3  funct3 size/sign field as produced by the control unit.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data (rs2).
REQ-011 busy  output  1  high in ACCESS and DONE states.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  valid with done: access failed.
REQ-014 rdata  output  32  extended load result; held until the next accepted start.
REQ-015 mem_req  output  1  bus request.
REQ-016 mem_we  output  1  bus write strobe.
REQ-017 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-018 mem_be  output  4  byte enables.
REQ-019 mem_wdata  output  32  lane-replicated store data.
REQ-020 mem_rdata  input  32  bus read data, valid with mem_ack.
REQ-021 mem_ack  input  1  bus completion.

Function
REQ-022 States SHALL be IDLE, ACCESS and DONE.
REQ-023 In IDLE with start=1, the block SHALL latch is_load, is_store, func, addr and wdata, and clear err.
- Legal request: next state ACCESS.
- Otherwise: next state DONE with err=1; mem_req is never asserted.
REQ-024 The request SHALL be illegal if any of the following holds:
- is_load and is_store are both 1, or both 0.
- Load func is not in {000,001,010,100,101}.
- Store func is not in {000,001,010}.
- Halfword access with addr[0]=1.
- Word access with addr[1:0]!=00.
REQ-025 In ACCESS, outputs SHALL be as follows; all bus outputs are registered and stable for the whole state:
- mem_req=1.
- mem_we=is_store.
- mem_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-026 ACCESS SHALL exit to DONE on the edge where mem_ack=1; a load then captures into rdata the lane mem_rdata[8*addr[1:0]+:size]:
- Sign-extended for func 000/001.
- Zero-extended for 100/101.
- Unmodified for 010.
REQ-027 A 32-bit timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack. On reaching ACK_TIMEOUT: next state DONE, err=1, rdata=0, mem_req drops.
REQ-028 mem_ack in the same cycle the counter reaches ACK_TIMEOUT SHALL win: a normal completion with err=0.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 start SHALL be ignored while busy=1, including during the DONE cycle.
REQ-031 mem_ack SHALL be ignored outside ACCESS.
REQ-032 Latency SHALL be start edge n -> mem_req high cycle n+1 -> done high the cycle after the ack edge; minimum 2 cycles from start to done for a legal access and 1 cycle for an illegal one.
REQ-033 A store SHALL leave rdata unchanged.

Reset
REQ-034 reset SHALL immediately force the following, including mid-ACCESS (a pending bus access is abandoned):
- State IDLE.
- busy, done, err, mem_req and mem_we = 0.
- mem_be = 0000.
- mem_addr, mem_wdata and rdata = 0.
- Timeout counter = 0.

Structure
REQ-035 funct3 size codes (FUNC_B/H/W/BU/HU) and state encodings SHALL reside in the shared control-unit constants file.
REQ-036 A combinational sub-module mem_lane_align SHALL compute mem_be, mem_wdata and the extended load value from func, addr[1:0], wdata and mem_rdata.

Verification
REQ-037 LB, addr=0x103, mem_rdata=0x80FFFFFF, ack in first ACCESS cycle -> mem_be=1000, rdata=0xFFFFFF80, err=0, done exactly 2 cycles after start.
REQ-038 SH, addr=0x22, wdata=0x1234ABCD, ack after 3 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD held stable for all ACCESS cycles.
REQ-039 LW, addr=0x41 -> no mem_req, done next cycle with err=1; then LHU, addr=0x42, mem_rdata=0xBEEF0000 -> rdata=0x0000BEEF.
REQ-040 ACK_TIMEOUT=4, LW with no ack -> mem_req high 4 cycles, then done=1, err=1, rdata=0; repeat with ack on the 4th cycle -> err=0.
REQ-041 Assert reset during ACCESS -> mem_req=0 and busy=0 before the next clk edge; a subsequent mem_ack produces no done.
REQ-042 start held high through DONE -> exactly one access performed; is_load=is_store=1 -> err=1.
